decode_hazard_ctrl: RTL and testbench

- Owns the IF/ID pipeline register of the RISC-V core and decides, every cycle, whether the front end advances, stalls or flushes.
- Decodes rs1/rs2 usage from the held instruction by opcode class (load, store, branch, R, I-ALU, JAL, JALR, LUI, AUIPC) and detects load-use hazards against the ID/EX stage.
- Applies taken-branch flushes and data-memory busy holds.
- Drives the PC write enable and the ID/EX bubble request; the immediate generator and register file consume id_inst.

---
 rtl/decode_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_ctrl.sv
// Purpose : IF/ID pipeline register plus front-end hazard control (load-use stall,
//           taken-branch flush, data-memory busy hold).
// Latency : control outputs are combinational from state/inputs; IF/ID updates on the next edge.
// Backpressure: mem_busy freezes IF/ID, PC and ID/EX; a load-use hazard stalls IF/ID and PC one cycle.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_pc, if_inst                   fetch-stage PC and instruction word
//   ex_mem_read, ex_rd               load-in-EX indication and its destination register
//   ex_branch_taken                  branch/jump in EX resolved taken
//   mem_busy                         data memory not ready, whole pipe holds
//   pc_write                         PC may load its next value this edge
//   idex_bubble, idex_hold           ID/EX loads zero control / keeps its contents
//   id_pc, id_inst, id_valid         IF/ID register contents
//   stall_count, flush_count         saturating event counters
module decode_hazard_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             rs1_used, rs2_used, lu_hazard;
  logic             load_ifid, flush_ifid, inc_stall, inc_flush;

  // Source-register usage by opcode class of the instruction held in ID.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_inst_q[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: rs1_used = 1'b1;      // load, I-ALU, JALR
      7'b0100011, 7'b1100011, 7'b0110011: begin                 // store, branch, R-type
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: ;                                                // LUI, AUIPC, JAL, other
    endcase
  end

  // x0 is never a real dependency, so ex_rd==0 cannot cause a stall.
  assign lu_hazard = id_valid_q & ex_mem_read & (ex_rd != 5'd0) &
                     ((rs1_used & (ex_rd == id_inst_q[19:15])) |
                      (rs2_used & (ex_rd == id_inst_q[24:20])));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. HOLD re-evaluates exactly like RUN once memory frees up.
  always_comb begin
    state_d = state_q;
    if (mem_busy) begin
      state_d = ST_HOLD;
    end else if (ex_branch_taken) begin
      state_d = ST_RUN;
    end else if (state_q == ST_LU_STALL) begin
      state_d = ST_RUN;
    end else if (lu_hazard) begin
      state_d = ST_LU_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Output logic. In LU_STALL the hazard is ignored: the single bubble already sits in EX.
  always_comb begin
    pc_write    = 1'b1;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    load_ifid   = 1'b0;
    flush_ifid  = 1'b0;
    inc_stall   = 1'b0;
    inc_flush   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write  = 1'b0;
      idex_hold = 1'b1;
    end else if (ex_branch_taken) begin
      idex_bubble = 1'b1;
      flush_ifid  = 1'b1;
      inc_flush   = 1'b1;
    end else if (state_q == ST_LU_STALL) begin
      load_ifid = 1'b1;
    end else if (lu_hazard) begin
      pc_write    = 1'b0;
      idex_bubble = 1'b1;
      inc_stall   = 1'b1;
    end else begin
      load_ifid = 1'b1;
    end
  end

  // IF/ID datapath and saturating counters.
  always_comb begin
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_ifid) begin
      id_pc_d    = 32'd0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (load_ifid) begin
      id_pc_d    = if_pc;
      id_inst_d  = if_inst;
      id_valid_d = 1'b1;
    end
    if (inc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (inc_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_pc_q     <= 32'd0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Purpose : self-checking bench for decode_hazard_ctrl (vector table + scoreboard).
// Latency : combinational outputs checked before the edge, IF/ID and counters after it.
// Backpressure: mem_busy and load-use sequences are part of the vector table.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] if_pc, if_inst;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken, mem_busy;

  logic        pc_write, idex_bubble, idex_hold, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_write, s_idex_bubble, s_idex_hold, s_id_valid;
  logic [31:0] s_id_pc, s_id_inst;
  logic [1:0]  s_stall_count, s_flush_count;

  decode_hazard_ctrl dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_inst(if_inst),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write), .idex_bubble(idex_bubble),
    .idex_hold(idex_hold), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  decode_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_inst(if_inst),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(s_pc_write), .idex_bubble(s_idex_bubble),
    .idex_hold(s_idex_hold), .id_pc(s_id_pc), .id_inst(s_id_inst), .id_valid(s_id_valid),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mr;
    logic [4:0]  rd;
    logic        br;
    logic        busy;
    logic        pw;
    logic        bub;
    logic        hold;
    logic [31:0] ipc;
    logic [31:0] iinst;
    logic        ival;
    int          st;
    int          fl;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ipc;
    logic [31:0] iinst;
    logic        ival;
    int          st;
    int          fl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic [31:0] pc,
                              input logic [31:0] inst, input logic mr, input logic [4:0] rd,
                              input logic br, input logic bz, input logic pw, input logic bub,
                              input logic hd, input logic [31:0] ipc, input logic [31:0] iinst,
                              input logic iv, input int st, input int fl);
    vec_t v;
    v.name = n; v.rst = r; v.pc = pc; v.inst = inst; v.mr = mr; v.rd = rd;
    v.br = br; v.busy = bz; v.pw = pw; v.bub = bub; v.hold = hd;
    v.ipc = ipc; v.iinst = iinst; v.ival = iv; v.st = st; v.fl = fl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset           = v.rst;
    if_pc           = v.pc;
    if_inst         = v.inst;
    ex_mem_read     = v.mr;
    ex_rd           = v.rd;
    ex_branch_taken = v.br;
    mem_busy        = v.busy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    //                    name                 rst pc        inst          mr   rd    br   bz   pw   bub  hd   id_pc     id_inst       iv   st fl
    vecs.push_back(mk("rst0",               1, 32'h100, 32'h00500093, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0,   32'h00000013, 0, 0, 0));
    vecs.push_back(mk("rst1",               1, 32'h100, 32'h00500093, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0,   32'h00000013, 0, 0, 0));
    vecs.push_back(mk("run_first",          0, 32'h100, 32'h00500093, 0, 5'd0, 0, 0, 1, 0, 0, 32'h100, 32'h00500093, 1, 0, 0));
    vecs.push_back(mk("run_add",            0, 32'h104, 32'h00728333, 0, 5'd0, 0, 0, 1, 0, 0, 32'h104, 32'h00728333, 1, 0, 0));
    vecs.push_back(mk("lu_stall",           0, 32'h108, 32'h00005337, 1, 5'd5, 0, 0, 0, 1, 0, 32'h104, 32'h00728333, 1, 1, 0));
    vecs.push_back(mk("lu_release",         0, 32'h108, 32'h00005337, 0, 5'd5, 0, 0, 1, 0, 0, 32'h108, 32'h00005337, 1, 1, 0));
    vecs.push_back(mk("lui_no_haz",         0, 32'h10C, 32'h00000333, 1, 5'd5, 0, 0, 1, 0, 0, 32'h10C, 32'h00000333, 1, 1, 0));
    vecs.push_back(mk("x0_no_haz",          0, 32'h110, 32'h00728333, 1, 5'd0, 0, 0, 1, 0, 0, 32'h110, 32'h00728333, 1, 1, 0));
    vecs.push_back(mk("flush_vs_lu",        0, 32'h114, 32'h0062A023, 1, 5'd7, 1, 0, 1, 1, 0, 32'h0,   32'h00000013, 0, 1, 1));
    vecs.push_back(mk("after_flush",        0, 32'h200, 32'h00728333, 0, 5'd0, 0, 0, 1, 0, 0, 32'h200, 32'h00728333, 1, 1, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("busy_freeze",      0, 32'h204, 32'h0062A023, 1, 5'd5, 1, 1, 0, 0, 1, 32'h200, 32'h00728333, 1, 1, 1));
    vecs.push_back(mk("busy_release_flush", 0, 32'h204, 32'h0062A023, 1, 5'd5, 1, 0, 1, 1, 0, 32'h0,   32'h00000013, 0, 1, 2));
    vecs.push_back(mk("refill",             0, 32'h300, 32'h00728333, 0, 5'd0, 0, 0, 1, 0, 0, 32'h300, 32'h00728333, 1, 1, 2));
    vecs.push_back(mk("busy_haz",           0, 32'h304, 32'h0062A023, 1, 5'd5, 0, 1, 0, 0, 1, 32'h300, 32'h00728333, 1, 1, 2));
    vecs.push_back(mk("hold_haz",           0, 32'h304, 32'h0062A023, 1, 5'd5, 0, 0, 0, 1, 0, 32'h300, 32'h00728333, 1, 2, 2));
    vecs.push_back(mk("stall_ignores_haz",  0, 32'h304, 32'h0062A023, 1, 5'd5, 0, 0, 1, 0, 0, 32'h304, 32'h0062A023, 1, 2, 2));
    vecs.push_back(mk("store_rs2_haz",      0, 32'h308, 32'h00000013, 1, 5'd6, 0, 0, 0, 1, 0, 32'h304, 32'h0062A023, 1, 3, 2));
    vecs.push_back(mk("store_release",      0, 32'h308, 32'h00000013, 0, 5'd6, 0, 0, 1, 0, 0, 32'h308, 32'h00000013, 1, 3, 2));
    vecs.push_back(mk("nop_no_haz",         0, 32'h30C, 32'h0002A303, 1, 5'd5, 0, 0, 1, 0, 0, 32'h30C, 32'h0002A303, 1, 3, 2));
    vecs.push_back(mk("rst_vs_branch",      1, 32'h310, 32'h00728333, 1, 5'd5, 1, 0, 0, 1, 0, 32'h0,   32'h00000013, 0, 0, 0));
    vecs.push_back(mk("rst_vs_busy",        1, 32'h310, 32'h00728333, 0, 5'd0, 0, 1, 0, 1, 0, 32'h0,   32'h00000013, 0, 0, 0));
    vecs.push_back(mk("run_after_rst",      0, 32'h400, 32'h00500093, 0, 5'd0, 0, 0, 1, 0, 0, 32'h400, 32'h00500093, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      #1;
      chk({v.name, ".pc_write"},    {31'd0, pc_write},    {31'd0, v.pw});
      chk({v.name, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, v.bub});
      chk({v.name, ".idex_hold"},   {31'd0, idex_hold},   {31'd0, v.hold});
      e.name = v.name; e.ipc = v.ipc; e.iinst = v.iinst; e.ival = v.ival; e.st = v.st; e.fl = v.fl;
      sb.push_back(e);
      step();
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        chk({e.name, ".id_pc"},       id_pc,                   e.ipc);
        chk({e.name, ".id_inst"},     id_inst,                 e.iinst);
        chk({e.name, ".id_valid"},    {31'd0, id_valid},       {31'd0, e.ival});
        chk({e.name, ".stall_count"}, {16'd0, stall_count},    e.st);
        chk({e.name, ".flush_count"}, {16'd0, flush_count},    e.fl);
      end
    end

    // Saturation: prime ID with add x6,x5,x7, then five load-use stalls and four flushes.
    reset = 0; if_pc = 32'h500; if_inst = 32'h00728333;
    ex_mem_read = 0; ex_rd = 5'd5; ex_branch_taken = 0; mem_busy = 0;
    step();
    chk("sat.start_count", {30'd0, s_stall_count}, 32'd0);
    chk("sat.primed_inst", s_id_inst, 32'h00728333);
    ex_mem_read = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("sat.stall_pc_write", {31'd0, s_pc_write}, 32'd1);
      step();
    end
    chk("sat.stall_count_narrow", {30'd0, s_stall_count}, 32'd3);
    chk("sat.stall_count_wide",   {16'd0, stall_count},   32'd5);
    ex_mem_read = 0;
    ex_branch_taken = 1;
    for (int k = 0; k < 4; k++) step();
    chk("sat.flush_count_narrow", {30'd0, s_flush_count}, 32'd3);
    chk("sat.flush_count_wide",   {16'd0, flush_count},   32'd4);
    chk("sat.stall_frozen",       {30'd0, s_stall_count}, 32'd3);
    ex_branch_taken = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
